crc_serial_sched: RTL and testbench

Round-robin scheduler that shares one bit-serial CRC-8 engine between two requesters. Accepts a parallel data word per request, streams it MSB-first into the serial LFSR followed by 8 augment bits, and returns the remainder with a requester tag. In generate mode the augment bits are zeros and the remainder is the CRC. In check mode the augment bits are the received CRC and a non-zero remainder flags an error. Sits between packet framing logic and the serial CRC datapath.

---
 rtl/crc_pkg.sv | 20 ++
 rtl/crc8_serial_core.sv | 22 ++
 rtl/crc_serial_sched.sv | 119 +++++++++++
 tb/tb_crc_serial_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and constants for the serial CRC-8 scheduler and its LFSR core.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int CRC_W = 8;
  localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;

  // One bit-serial LFSR step; the x^8 term is implicit in the feedback tap.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] lfsr,
                                                 input logic             bit_in,
                                                 input logic [CRC_W-1:0] poly);
    return {lfsr[CRC_W-2:0], bit_in} ^ (lfsr[CRC_W-1] ? poly : '0);
  endfunction

endpackage

// File: rtl/crc8_serial_core.sv
// Bit-serial CRC-8 LFSR: one message bit per enabled cycle, cleared on clr.
module crc8_serial_core
  import crc_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [CRC_W-1:0] POLY,
  output logic [CRC_W-1:0] lfsr
);

  always_ff @(posedge CLK) begin
    if (!RST || clr) begin
      lfsr <= '0;
    end else if (en) begin
      lfsr <= crc8_step(lfsr, bit_in, POLY);
    end
  end

endmodule

// File: rtl/crc_serial_sched.sv
// Round-robin scheduler sharing one serial CRC-8 core between two requesters.
module crc_serial_sched
  import crc_pkg::*;
#(
  parameter int               DW   = 32,
  parameter logic [CRC_W-1:0] POLY = CRC8_POLY
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DW-1:0]     req_data,
  input  logic [1:0]          req_mode,
  input  logic [2*CRC_W-1:0]  req_crc,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_id,
  output logic [CRC_W-1:0]    res_crc,
  output logic                res_err,
  output logic                busy
);

  localparam int SR_W  = DW + CRC_W;
  localparam int CNT_W = $clog2(DW + 9);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DW + 7);

  state_t            state;
  logic              prio;
  logic              mode;
  logic [SR_W-1:0]   sr;
  logic [CNT_W-1:0]  cnt;
  logic [CRC_W-1:0]  lfsr;
  logic [CRC_W-1:0]  crc_next;
  logic [1:0]        grant;
  logic              hs;
  logic              hs_id;
  logic [DW-1:0]     sel_data;
  logic [CRC_W-1:0]  sel_crc;
  logic              sel_mode;

  always_comb begin
    grant = 2'b00;
    if (!prio) begin
      if (req_valid[0])      grant = 2'b01;
      else if (req_valid[1]) grant = 2'b10;
    end else begin
      if (req_valid[1])      grant = 2'b10;
      else if (req_valid[0]) grant = 2'b01;
    end
  end

  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign hs_id     = req_ready[1];
  assign sel_data  = hs_id ? req_data[2*DW-1:DW] : req_data[DW-1:0];
  assign sel_crc   = hs_id ? req_crc[2*CRC_W-1:CRC_W] : req_crc[CRC_W-1:0];
  assign sel_mode  = req_mode[hs_id];

  // The final remainder must include the bit shifted on the last edge,
  // so the result is taken from the core's next value, not its register.
  assign crc_next = crc8_step(lfsr, sr[SR_W-1], POLY);

  crc8_serial_core u_core (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (hs),
    .en     (state == SHIFT),
    .bit_in (sr[SR_W-1]),
    .POLY   (POLY),
    .lfsr   (lfsr)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      prio      <= 1'b0;
      mode      <= 1'b0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_crc   <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            sr     <= {sel_data, sel_mode ? sel_crc : {CRC_W{1'b0}}};
            mode   <= sel_mode;
            res_id <= hs_id;
            cnt    <= '0;
            prio   <= ~hs_id;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= {sr[SR_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            res_crc   <= crc_next;
            res_err   <= mode & (|crc_next);
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_serial_sched.sv
// Scoreboard bench for crc_serial_sched: generate/check jobs, arbitration, backpressure, reset.
module tb_crc_serial_sched;

  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [2*DW-1:0] req_data = '0;
  logic [1:0]    req_mode = 2'b00;
  logic [15:0]   req_crc = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          res_id;
  logic [7:0]    res_crc;
  logic          res_err;
  logic          busy;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic       id;
    logic [7:0] crc;
    logic       err;
  } exp_t;

  exp_t sbq[$];

  crc_serial_sched #(.DW(DW), .POLY(8'h07)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .req_crc   (req_crc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_crc   (res_crc),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Byte-wise, non-augmented CRC-8; check mode folds in the received CRC.
  function automatic exp_t model(input logic id, input logic [31:0] d, input logic m,
                                 input logic [7:0] c);
    logic [7:0] x;
    exp_t e;
    x = 8'h00;
    for (int b = 3; b >= 0; b--) begin
      x = x ^ d[b*8 +: 8];
      for (int k = 0; k < 8; k++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    end
    e.id  = id;
    e.crc = m ? (x ^ c) : x;
    e.err = m && (e.crc != 8'h00);
    return e;
  endfunction

  task automatic issue(input int r, input logic [31:0] d, input logic m, input logic [7:0] c);
    bit ok;
    ok = 0;
    req_data[r*DW +: DW] = d;
    req_mode[r]          = m;
    req_crc[r*8 +: 8]    = c;
    req_valid[r]         = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req_ready[r]) begin
        ok = 1;
        break;
      end
      @(posedge CLK);
    end
    if (ok) sbq.push_back(model(r[0], d, m, c));
    else begin
      errs++;
      $display("FAIL issue_timeout: req_ready[%0d] never rose", r);
    end
    vecs++;
    @(posedge CLK);
    #1;
    req_valid[r] = 1'b0;
    req_data[r*DW +: DW] = ~d;
    req_mode[r] = ~m;
    req_crc[r*8 +: 8] = ~c;
  endtask

  task automatic collect(output bit got, output int lat, output logic id,
                         output logic [7:0] crc, output logic err);
    got = 0;
    lat = 0;
    id  = 1'b0;
    crc = 8'h00;
    err = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (res_valid) begin
        got = 1;
        break;
      end
      @(posedge CLK);
      #1;
      lat++;
    end
    if (got) begin
      id  = res_id;
      crc = res_crc;
      err = res_err;
      res_ready = 1'b1;
      @(posedge CLK);
      #1;
      res_ready = 1'b0;
    end else begin
      errs++;
      vecs++;
      $display("FAIL result_timeout: res_valid never rose");
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vecs++; if (req_ready !== 2'b00) begin errs++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    vecs++; if (res_id !== 1'b0) begin errs++; $display("FAIL rst_res_id: got %b want 0", res_id); end
    vecs++; if (res_crc !== 8'h00) begin errs++; $display("FAIL rst_res_crc: got %h want 00", res_crc); end
    vecs++; if (res_err !== 1'b0) begin errs++; $display("FAIL rst_res_err: got %b want 0", res_err); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
    RST = 1'b1;
  endtask

  task automatic test_generate();
    bit got; int lat; logic id; logic [7:0] crc; logic err; exp_t e;
    issue(0, 32'h0000000D, 1'b0, 8'h5A);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL gen_busy: got %b want 1", busy); end
    collect(got, lat, id, crc, err);
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      vecs++;
      if ({id, crc, err} !== {e.id, e.crc, e.err}) begin
        errs++; $display("FAIL gen_result: got id=%b crc=%h err=%b want id=%b crc=%h err=%b", id, crc, err, e.id, e.crc, e.err);
      end
      vecs++; if (crc !== 8'h23) begin errs++; $display("FAIL gen_crc_const: got %h want 23", crc); end
      vecs++; if (lat != DW + 8) begin errs++; $display("FAIL gen_latency: got %0d want %0d", lat, DW + 8); end
    end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL gen_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_check_pass();
    bit got; int lat; logic id; logic [7:0] crc; logic err; exp_t e;
    issue(1, 32'h0000000D, 1'b1, 8'h23);
    collect(got, lat, id, crc, err);
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      vecs++;
      if ({id, crc, err} !== {e.id, e.crc, e.err}) begin
        errs++; $display("FAIL chk_pass_result: got id=%b crc=%h err=%b want id=%b crc=%h err=%b", id, crc, err, e.id, e.crc, e.err);
      end
      vecs++; if ({id, crc, err} !== {1'b1, 8'h00, 1'b0}) begin errs++; $display("FAIL chk_pass_const: got id=%b crc=%h err=%b want 1/00/0", id, crc, err); end
    end
  endtask

  task automatic test_check_fail();
    bit got; int lat; logic id; logic [7:0] crc; logic err; exp_t e;
    issue(0, 32'h0000000D, 1'b1, 8'h24);
    collect(got, lat, id, crc, err);
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      vecs++;
      if ({id, crc, err} !== {e.id, e.crc, e.err}) begin
        errs++; $display("FAIL chk_fail_result: got id=%b crc=%h err=%b want id=%b crc=%h err=%b", id, crc, err, e.id, e.crc, e.err);
      end
      vecs++; if (err !== 1'b1 || crc === 8'h00) begin errs++; $display("FAIL chk_fail_flag: got err=%b crc=%h want err=1 crc!=00", err, crc); end
    end
  endtask

  task automatic test_arbitration();
    int done; int nb; int both_hi; logic [3:0] order; exp_t e;
    do_reset();
    req_data  = {32'h0000000D, 32'hDEADBEEF};
    req_mode  = 2'b10;
    req_crc   = {8'h23, 8'h00};
    req_valid = 2'b11;
    done = 0; nb = 0; both_hi = 0; order = 4'b0000;
    for (int cyc = 0; cyc < 400 && done < 4; cyc++) begin
      #1;
      res_ready = 1'b0;
      if (req_ready == 2'b11) both_hi++;
      if (req_ready[0]) begin
        sbq.push_back(model(1'b0, 32'hDEADBEEF, 1'b0, 8'h00));
        if (nb < 4) order[nb] = 1'b0;
        nb++;
      end else if (req_ready[1]) begin
        sbq.push_back(model(1'b1, 32'h0000000D, 1'b1, 8'h23));
        if (nb < 4) order[nb] = 1'b1;
        nb++;
      end
      if (res_valid) begin
        vecs++;
        if (sbq.size() == 0) begin
          errs++; $display("FAIL arb_unexpected: result id=%b with no job outstanding", res_id);
        end else begin
          e = sbq.pop_front();
          if ({res_id, res_crc, res_err} !== {e.id, e.crc, e.err}) begin
            errs++; $display("FAIL arb_result: got id=%b crc=%h err=%b want id=%b crc=%h err=%b", res_id, res_crc, res_err, e.id, e.crc, e.err);
          end
        end
        res_ready = 1'b1;
        done++;
      end
      @(posedge CLK);
    end
    #1;
    res_ready = 1'b0;
    req_valid = 2'b00;
    vecs++; if (done != 4) begin errs++; $display("FAIL arb_count: got %0d results want 4", done); end
    vecs++; if (order !== 4'b1010) begin errs++; $display("FAIL arb_order: got %b (bit0 first) want 1010", order); end
    vecs++; if (both_hi != 0) begin errs++; $display("FAIL arb_onehot: req_ready=11 seen %0d times want 0", both_hi); end
    sbq.delete();
  endtask

  task automatic test_backpressure();
    bit got; logic [10:0] snap; exp_t e;
    issue(1, 32'hCAFEF00D, 1'b0, 8'h00);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (res_valid) begin got = 1; break; end
      @(posedge CLK);
      #1;
    end
    vecs++;
    if (!got) begin
      errs++; $display("FAIL bp_timeout: res_valid never rose");
    end else begin
      snap = {res_valid, res_id, res_crc, res_err};
      req_valid = 2'b11;
      for (int i = 0; i < 10; i++) begin
        @(posedge CLK);
        #1;
        vecs++;
        if ({res_valid, res_id, res_crc, res_err, req_ready, busy} !== {snap, 2'b00, 1'b1}) begin
          errs++; $display("FAIL bp_hold[%0d]: got res=%h ready=%b busy=%b want res=%h ready=00 busy=1",
                           i, {res_valid, res_id, res_crc, res_err}, req_ready, busy, snap);
        end
      end
      req_valid = 2'b00;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        vecs++;
        if (snap[9:0] !== {e.id, e.crc, e.err}) begin
          errs++; $display("FAIL bp_result: got %h want %h", snap[9:0], {e.id, e.crc, e.err});
        end
      end
      res_ready = 1'b1;
      @(posedge CLK);
      #1;
      res_ready = 1'b0;
      vecs++; if ({res_valid, busy} !== 2'b00) begin errs++; $display("FAIL bp_consume: got valid/busy=%b want 00", {res_valid, busy}); end
    end
  endtask

  task automatic test_reset_mid();
    bit got; int lat; logic id; logic [7:0] crc; logic err; exp_t e;
    do_reset();
    issue(0, 32'hA5A55A5A, 1'b0, 8'h00);
    void'(sbq.pop_back());
    repeat (19) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL mid_res_valid: got %b want 0", res_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %b want 0", busy); end
    RST = 1'b1;
    req_valid = 2'b11;
    #1;
    vecs++; if (req_ready !== 2'b01) begin errs++; $display("FAIL mid_priority: got req_ready=%b want 01", req_ready); end
    req_valid[1] = 1'b0;
    issue(0, 32'h12345678, 1'b1, 8'hAB);
    collect(got, lat, id, crc, err);
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      vecs++;
      if ({id, crc, err} !== {e.id, e.crc, e.err}) begin
        errs++; $display("FAIL mid_next_result: got id=%b crc=%h err=%b want id=%b crc=%h err=%b", id, crc, err, e.id, e.crc, e.err);
      end
      vecs++; if (lat != DW + 8) begin errs++; $display("FAIL mid_next_latency: got %0d want %0d", lat, DW + 8); end
    end
  endtask

  initial begin
    test_reset();
    test_generate();
    test_check_pass();
    test_check_fail();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
